uart_rx_ctrl: RTL and testbench

//  Sequences the UART receive FIFO: writes deserialized bytes from the RX shifter into the FIFO,

---
 rtl/uart_rx_ctrl_pkg.sv | 15 +
 rtl/uart_rx_tout_timer.sv | 31 +++
 rtl/uart_rx_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART RX FIFO sequencer.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } rd_state_e;

  localparam int INTR_OVF  = 0;
  localparam int INTR_TOUT = 1;
  localparam int INTR_ERR  = 2;

endpackage

// File: rtl/uart_rx_tout_timer.sv
// Idle-timeout counter: counts while enabled, saturates at the limit and
// emits a single-cycle hit on the step that reaches it.
module uart_rx_tout_timer #(
  parameter int TOUT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [TOUT_W-1:0] limit_i,
  output logic              hit_o
);

  localparam logic [TOUT_W-1:0] ONE = TOUT_W'(1);

  logic [TOUT_W-1:0] cnt_q;
  logic              at_limit, at_max, step;

  assign at_limit = (cnt_q == limit_i);
  assign at_max   = &cnt_q;
  // Holding at the limit keeps the hit from repeating until the next clear.
  assign step     = en_i && !clr_i && !at_limit && !at_max;
  assign hit_o    = step && ((cnt_q + ONE) == limit_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               cnt_q <= '0;
    else if (clr_i || !en_i)   cnt_q <= '0;
    else if (step)             cnt_q <= cnt_q + ONE;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX FIFO sequencer: write path from the shifter, req/ack single-byte
// read FSM, occupancy tracking and interrupt flags.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int TOUT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_en_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_err_i,
  output logic              fifo_wr_en_o,
  output logic [7:0]        fifo_wdata_o,
  output logic              fifo_rd_en_o,
  input  logic [7:0]        fifo_rdata_i,
  output logic              fifo_clr_o,
  input  logic              bus_rd_req_i,
  output logic              bus_rd_ack_o,
  output logic [7:0]        bus_rd_data_o,
  input  logic              fifo_clr_i,
  input  logic [CNT_W-1:0]  thresh_i,
  input  logic [TOUT_W-1:0] tout_i,
  input  logic [2:0]        intr_clr_i,
  output logic [CNT_W-1:0]  level_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              intr_thresh_o,
  output logic              intr_ovf_o,
  output logic              intr_tout_o,
  output logic              intr_err_o
);

  localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] level_q;
  logic [7:0]       rdata_q, wdata_q;
  logic             wr_q, clr_q;
  logic [2:0]       intr_q, intr_set;
  logic             full, empty, fetch;
  logic             rx_take, wr_acc, wr_do, tout_hit;

  assign full    = (level_q == LVL_MAX);
  assign empty   = (level_q == '0);
  assign fetch   = (state_q == FETCH);
  assign rx_take = rx_valid_i && rx_en_i;
  // Room is judged on the registered level; a read in flight frees nothing yet.
  assign wr_acc  = rx_take && !full;
  assign wr_do   = wr_acc && !fifo_clr_i;

  always_comb begin
    intr_set            = '0;
    intr_set[INTR_OVF]  = rx_take && full;
    intr_set[INTR_TOUT] = tout_hit;
    intr_set[INTR_ERR]  = wr_do && rx_err_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_rd_req_i) state_d = (empty || fifo_clr_i) ? ACK : FETCH;
      FETCH:   state_d = fifo_clr_i ? ACK : CAPT;
      CAPT:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      level_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      clr_q   <= 1'b0;
      intr_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_do;
      clr_q   <= fifo_clr_i;
      if (wr_do) wdata_q <= rx_data_i;
      if (fifo_clr_i)            level_q <= '0;
      else if (wr_do && !fetch)  level_q <= level_q + ONE;
      else if (!wr_do && fetch)  level_q <= level_q - ONE;
      // Any entry into ACK other than a clean CAPT returns 0x00.
      if (state_d == ACK && state_q != ACK)
        rdata_q <= (state_q == CAPT && !fifo_clr_i) ? fifo_rdata_i : 8'h00;
      intr_q  <= intr_set | (intr_q & ~intr_clr_i);
    end
  end

  uart_rx_tout_timer #(.TOUT_W(TOUT_W)) u_tout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (wr_acc || fetch || empty || fifo_clr_i),
    .en_i    (rx_en_i && (tout_i != '0)),
    .limit_i (tout_i),
    .hit_o   (tout_hit)
  );

  assign fifo_wr_en_o  = wr_q;
  assign fifo_wdata_o  = wdata_q;
  assign fifo_rd_en_o  = fetch;
  assign fifo_clr_o    = clr_q;
  assign bus_rd_ack_o  = (state_q == ACK);
  assign bus_rd_data_o = (state_q == ACK) ? rdata_q : 8'h00;
  assign level_o       = level_q;
  assign empty_o       = empty;
  assign full_o        = full;
  assign intr_thresh_o = (thresh_i != '0) && (level_q >= thresh_i);
  assign intr_ovf_o    = intr_q[INTR_OVF];
  assign intr_tout_o   = intr_q[INTR_TOUT];
  assign intr_err_o    = intr_q[INTR_ERR];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a queue model of FIFO contents predicts
// read data/latency and written bytes; a monitor checks them as the DUT emits them.
module tb_uart_rx_ctrl;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int TOUT_W = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              rx_en_i, rx_valid_i, rx_err_i;
  logic [7:0]        rx_data_i;
  logic              fifo_wr_en_o, fifo_rd_en_o, fifo_clr_o;
  logic [7:0]        fifo_wdata_o, fifo_rdata_i;
  logic              bus_rd_req_i, bus_rd_ack_o;
  logic [7:0]        bus_rd_data_o;
  logic              fifo_clr_i;
  logic [CNT_W-1:0]  thresh_i;
  logic [TOUT_W-1:0] tout_i;
  logic [2:0]        intr_clr_i;
  logic [CNT_W-1:0]  level_o;
  logic              empty_o, full_o, intr_thresh_o, intr_ovf_o, intr_tout_o, intr_err_o;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TOUT_W(TOUT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_en_i(rx_en_i), .rx_valid_i(rx_valid_i),
    .rx_data_i(rx_data_i), .rx_err_i(rx_err_i), .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_rd_en_o(fifo_rd_en_o), .fifo_rdata_i(fifo_rdata_i),
    .fifo_clr_o(fifo_clr_o), .bus_rd_req_i(bus_rd_req_i), .bus_rd_ack_o(bus_rd_ack_o),
    .bus_rd_data_o(bus_rd_data_o), .fifo_clr_i(fifo_clr_i), .thresh_i(thresh_i),
    .tout_i(tout_i), .intr_clr_i(intr_clr_i), .level_o(level_o), .empty_o(empty_o),
    .full_o(full_o), .intr_thresh_o(intr_thresh_o), .intr_ovf_o(intr_ovf_o),
    .intr_tout_o(intr_tout_o), .intr_err_o(intr_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] data; int cyc; } rd_exp_t;

  rd_exp_t    rd_q[$];
  rd_exp_t    mon_e;
  logic [7:0] wr_q[$];
  logic [7:0] mq[$];       // model: bytes the controller should hold
  logic [7:0] hw_fifo[$];  // storage the controller drives
  int         nvec = 0, nerr = 0, cyc = 0, op;
  bit         m_ovf, m_err, m_tout;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hw_fifo.delete();
      fifo_rdata_i <= 8'h00;
    end else begin
      if (fifo_rd_en_o) fifo_rdata_i <= (hw_fifo.size() > 0) ? hw_fifo.pop_front() : 8'hEE;
      if (fifo_wr_en_o) hw_fifo.push_back(fifo_wdata_o);
      if (fifo_clr_o)   hw_fifo.delete();
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus_rd_ack_o) begin
        if (rd_q.size() == 0) chk("rd_ack_unexpected", 1, 0);
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_data", bus_rd_data_o, mon_e.data);
          chk("rd_latency", cyc, mon_e.cyc);
        end
      end
      if (fifo_wr_en_o) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else chk("wr_data", fifo_wdata_o, wr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic void model_write(input logic [7:0] b, input bit err);
    if (rx_en_i) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(b);
        wr_q.push_back(b);
        if (err) m_err = 1'b1;
      end else m_ovf = 1'b1;
    end
  endfunction

  task automatic wr(input logic [7:0] b, input bit err);
    rx_valid_i = 1'b1; rx_data_i = b; rx_err_i = err;
    model_write(b, err);
    tick();
    rx_valid_i = 1'b0; rx_err_i = 1'b0;
  endtask

  task automatic rd_issue();
    rd_exp_t e;
    bus_rd_req_i = 1'b1;
    if (mq.size() == 0) begin e.data = 8'h00; e.cyc = cyc + 1; end
    else begin e.data = mq.pop_front(); e.cyc = cyc + 3; end
    rd_q.push_back(e);
  endtask

  task automatic rd_wait();
    bit got = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (bus_rd_ack_o) begin got = 1'b1; break; end
      tick();
    end
    chk("rd_ack_seen", got, 1);
    tick();
    bus_rd_req_i = 1'b0;
  endtask

  task automatic rd();
    rd_issue();
    rd_wait();
  endtask

  task automatic flush();
    fifo_clr_i = 1'b1;
    tick();
    fifo_clr_i = 1'b0;
    mq.delete();
    chk("flush.clr_pulse", fifo_clr_o, 1);
    chk("flush.level", level_o, 0);
    tick();
    chk("flush.clr_end", fifo_clr_o, 0);
  endtask

  task automatic iclr(input logic [2:0] v);
    intr_clr_i = v;
    tick();
    intr_clr_i = 3'b000;
    if (v[0]) m_ovf = 1'b0;
    if (v[1]) m_tout = 1'b0;
    if (v[2]) m_err = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".level"}, level_o, mq.size());
    chk({tag, ".empty"}, empty_o, mq.size() == 0);
    chk({tag, ".full"}, full_o, mq.size() == DEPTH);
    chk({tag, ".thresh"}, intr_thresh_o, (thresh_i != 0) && (mq.size() >= thresh_i));
    chk({tag, ".ovf"}, intr_ovf_o, m_ovf);
    chk({tag, ".err"}, intr_err_o, m_err);
    chk({tag, ".tout"}, intr_tout_o, m_tout);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_en"}, fifo_wr_en_o, 0);
    chk({tag, ".rd_en"}, fifo_rd_en_o, 0);
    chk({tag, ".clr"}, fifo_clr_o, 0);
    chk({tag, ".ack"}, bus_rd_ack_o, 0);
    chk({tag, ".rdata"}, bus_rd_data_o, 0);
    chk({tag, ".level"}, level_o, 0);
    chk({tag, ".empty"}, empty_o, 1);
    chk({tag, ".full"}, full_o, 0);
    chk({tag, ".intr"}, {intr_thresh_o, intr_ovf_o, intr_tout_o, intr_err_o}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; rx_en_i = 1'b1; rx_valid_i = 1'b0; rx_err_i = 1'b0; rx_data_i = 8'h00;
    bus_rd_req_i = 1'b0; fifo_clr_i = 1'b0; thresh_i = '0; tout_i = '0; intr_clr_i = 3'b000;
    m_ovf = 1'b0; m_err = 1'b0; m_tout = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    // in-order read-back
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0);
    chk_state("wr3");
    rd(); chk_state("rd1");
    rd(); chk_state("rd2");
    rd(); chk_state("rd3");

    // overflow, err suppression on a dropped byte, set-over-clear priority
    for (int i = 0; i < DEPTH + 1; i++) wr(8'($urandom), 0);
    chk_state("ovf");
    wr(8'hA5, 1);
    chk_state("ovf_err_dropped");
    rx_valid_i = 1'b1; rx_data_i = 8'h5A; intr_clr_i = 3'b001;
    model_write(8'h5A, 0);
    tick();
    rx_valid_i = 1'b0; intr_clr_i = 3'b000;
    chk_state("ovf_set_wins");
    iclr(3'b001);
    chk_state("ovf_clr");
    flush();
    chk_state("flush_full");

    // threshold
    thresh_i = 4;
    wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0);
    chk_state("thr3");
    wr(8'h04, 0);
    chk_state("thr4");
    rd();
    chk_state("thr_rd");
    thresh_i = 0;
    while (mq.size() > 0) rd();

    // error flag on accepted byte
    wr(8'hE1, 1);
    chk_state("err_set");
    iclr(3'b100);
    chk_state("err_clr");
    rd();

    // idle timeout
    tout_i = 20;
    wr(8'h77, 0);
    repeat (19) tick();
    chk("tout.before", intr_tout_o, 0);
    tick();
    chk("tout.at20", intr_tout_o, 1);
    m_tout = 1'b1;
    rd();
    iclr(3'b010);
    chk_state("tout_clr");
    tout_i = 0;
    wr(8'h78, 0);
    repeat (40) tick();
    chk_state("tout_disabled");
    rd();

    // read on empty
    rd();
    chk_state("rd_empty");

    // write coinciding with FETCH at level 5
    for (int i = 0; i < 5; i++) wr(8'($urandom), 0);
    rd_issue();
    tick();
    chk("sim.fetch_rd_en", fifo_rd_en_o, 1);
    chk("sim.fetch_level", level_o, mq.size() + 1);
    wr(8'hC3, 0);
    chk("sim.level_kept", level_o, 5);
    rd_wait();
    chk_state("sim_done");
    while (mq.size() > 0) rd();

    // flush while in CAPT at level 6
    for (int i = 0; i < 6; i++) wr(8'($urandom), 0);
    chk_state("pre_flush6");
    bus_rd_req_i = 1'b1;
    rd_q.push_back('{data: 8'h00, cyc: cyc + 3});
    tick();
    tick();
    chk("fcapt.level", level_o, 5);
    fifo_clr_i = 1'b1;
    tick();
    fifo_clr_i = 1'b0;
    mq.delete();
    chk("fcapt.clr_pulse", fifo_clr_o, 1);
    chk("fcapt.level0", level_o, 0);
    chk("fcapt.ack", bus_rd_ack_o, 1);
    rd_wait();
    chk("fcapt.clr_end", fifo_clr_o, 0);
    chk_state("fcapt_done");

    // randomized mix
    thresh_i = CNT_W'($urandom_range(0, DEPTH));
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 19);
      if (op < 9)       wr(8'($urandom), $urandom_range(0, 7) == 0);
      else if (op < 15) rd();
      else if (op < 17) tick();
      else if (op == 17) begin rx_en_i = ($urandom_range(0, 3) != 0); tick(); end
      else if (op == 18) flush();
      else iclr(3'($urandom));
      chk_state("rnd");
    end
    rx_en_i = 1'b1;

    // asynchronous reset during a read
    flush();
    wr(8'h91, 0); wr(8'h92, 0); wr(8'h93, 0);
    rd_issue();
    tick();
    tick();
    rst_ni = 1'b0;
    rd_q.delete(); mq.delete(); wr_q.delete();
    m_ovf = 1'b0; m_err = 1'b0; m_tout = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    bus_rd_req_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    repeat (6) tick();
    chk_state("post_rst");

    chk("end.rd_q_empty", rd_q.size(), 0);
    chk("end.wr_q_empty", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
